ologic_tx_gearbox: RTL and testbench

2:1 transmit gearbox that feeds the OLOGIC output serializers on gsclk_ol.
- Buffers double-width parallel words from the PHY write datapath in a small FIFO.
- Emits one half-word per gsclk_ol cycle, phase-locked to the align_ol toggle produced by the upstream alignment stage.
- Monitors align_ol for lock and loss of alignment, and reports FIFO underflows.

---
 rtl/ologic_pkg.sv | 19 +
 rtl/ologic_tx_fifo.sv | 59 +++++
 rtl/ologic_tx_gearbox.sv | 175 +++++++++++++++++
 tb/tb_ologic_tx_gearbox.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ologic_pkg.sv
// ologic_pkg
//   Shared types and constants for the OLOGIC transmit gearbox slice.
//   - state_t      : alignment/run state of the gearbox
//   - UF_CNT_W     : width of the saturating underflow counter
//   - UF_CNT_MAX   : saturation value of that counter
//   - IDLE_BIT     : bit value replicated to form the default idle pattern
package ologic_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKING  = 2'd1,
    ST_RUN      = 2'd2
  } state_t;

  localparam int                  UF_CNT_W   = 16;
  localparam logic [UF_CNT_W-1:0] UF_CNT_MAX = '1;
  localparam logic                IDLE_BIT   = 1'b0;

endpackage

// File: rtl/ologic_tx_fifo.sv
// ologic_tx_fifo
//   Synchronous FIFO holding double-width words ahead of the gearbox.
//   Pointers carry one extra wrap bit so full and empty are told apart
//   without a separate occupancy counter. No write-to-read bypass: a word
//   written at one edge is visible on rd_data from the following cycle.
// Ports:
//   gsclk_ol  in   clock
//   rst       in   synchronous active-high reset (empties the FIFO)
//   push      in   write wr_data when not full
//   pop       in   advance the read pointer when not empty
//   flush     in   discard all contents this edge (wins over push/pop)
//   wr_data   in   word to write
//   rd_data   out  word at the head of the FIFO
//   full      out  no free entry
//   empty     out  no stored entry
module ologic_tx_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic         gsclk_ol,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state is always assigned with <= so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge gsclk_ol) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array has no reset; the pointers alone decide which
  // entries are meaningful, so clearing the array would only cost logic.
  always_ff @(posedge gsclk_ol) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ologic_tx_gearbox.sv
// ologic_tx_gearbox
//   2:1 transmit gearbox feeding the OLOGIC serializers. Double-width words
//   are queued in a small FIFO and emitted as two half-words, low half first,
//   phase-locked to the align_ol toggle. Lock is declared after LOCK_CNT
//   consecutive toggles; a missing toggle in RUN drops lock, flushes the
//   queue and pulses align_err. Idle word slots inserted while locked are
//   counted in a saturating counter.
// Ports:
//   gsclk_ol       in   OLOGIC fabric clock
//   rst            in   synchronous active-high reset
//   align_ol       in   alignment phase, toggles every cycle when healthy
//   in_data        in   word; per lane low DW bits sent first, high DW second
//   in_valid       in   in_data valid
//   in_ready       out  word accepted when in_valid && in_ready
//   ol_data        out  registered half-word to OLOGIC
//   ol_first       out  ol_data holds the low half of a word (or idle slot)
//   locked         out  state is RUN
//   align_err      out  one-cycle pulse on loss of alignment
//   underflow_cnt  out  saturating count of idle word slots while locked
module ologic_tx_gearbox
  import ologic_pkg::*;
#(
  parameter int             DW         = 4,
  parameter int             LANES      = 8,
  parameter int             FIFO_DEPTH = 4,
  parameter int             LOCK_CNT   = 4,
  parameter logic [DW-1:0]  IDLE_PAT   = {DW{IDLE_BIT}}
) (
  input  logic                  gsclk_ol,
  input  logic                  rst,
  input  logic                  align_ol,
  input  logic [2*DW*LANES-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DW*LANES-1:0]   ol_data,
  output logic                  ol_first,
  output logic                  locked,
  output logic                  align_err,
  output logic [UF_CNT_W-1:0]   underflow_cnt
);

  localparam int                WW        = 2 * DW * LANES;
  localparam int                OW        = DW * LANES;
  localparam int                LCW       = $clog2(LOCK_CNT + 1);
  localparam logic [OW-1:0]     IDLE_WORD = {LANES{IDLE_PAT}};

  state_t               state;
  logic [LCW-1:0]       lock_cnt;
  logic                 align_q;
  logic [OW-1:0]        hold;
  logic [UF_CNT_W-1:0]  uf_cnt_q;

  logic                 toggle;
  logic                 load_edge;
  logic                 in_run;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_flush;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [WW-1:0]        fifo_head;
  logic [OW-1:0]        head_lo;
  logic [OW-1:0]        head_hi;

  assign toggle        = (align_ol != align_q);
  assign load_edge     = align_ol && toggle;
  assign in_run        = (state == ST_RUN);
  assign in_ready      = locked && !fifo_full;
  assign fifo_push     = in_valid && in_ready;
  assign fifo_pop      = in_run && load_edge && !fifo_empty;
  // A missed toggle in RUN discards the queue; this also drops any push
  // arriving on that same edge.
  assign fifo_flush    = in_run && !toggle;
  assign underflow_cnt = uf_cnt_q;

  ologic_tx_fifo #(
    .W     (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .gsclk_ol (gsclk_ol),
    .rst      (rst),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .flush    (fifo_flush),
    .wr_data  (in_data),
    .rd_data  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Split the head word into per-lane low and high halves.
  // NOTE: every variable written here gets a default first so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    head_lo = '0;
    head_hi = '0;
    for (int l = 0; l < LANES; l++) begin
      head_lo[l*DW +: DW] = fifo_head[l*2*DW      +: DW];
      head_hi[l*DW +: DW] = fifo_head[l*2*DW + DW +: DW];
    end
  end

  always_ff @(posedge gsclk_ol) begin
    if (rst) begin
      state     <= ST_UNLOCKED;
      lock_cnt  <= '0;
      align_q   <= 1'b0;
      ol_data   <= IDLE_WORD;
      ol_first  <= 1'b0;
      locked    <= 1'b0;
      align_err <= 1'b0;
      uf_cnt_q  <= '0;
      hold      <= IDLE_WORD;
    end else begin
      align_q   <= align_ol;
      // Idle unless a branch below emits data; hold is consumed once.
      align_err <= 1'b0;
      ol_data   <= IDLE_WORD;
      ol_first  <= 1'b0;
      hold      <= IDLE_WORD;
      locked    <= 1'b0;

      unique case (state)
        ST_UNLOCKED: begin
          if (toggle) begin
            state    <= ST_LOCKING;
            lock_cnt <= LCW'(1);
          end
        end

        ST_LOCKING: begin
          if (!toggle) begin
            state    <= ST_UNLOCKED;
            lock_cnt <= '0;
          end else if (lock_cnt == LCW'(LOCK_CNT - 1)) begin
            state    <= ST_RUN;
            lock_cnt <= LCW'(LOCK_CNT);
            locked   <= 1'b1;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end

        ST_RUN: begin
          if (!toggle) begin
            // Loss of alignment: the pending high half is dropped because
            // ol_data and hold fall back to their idle defaults above.
            state     <= ST_UNLOCKED;
            lock_cnt  <= '0;
            align_err <= 1'b1;
          end else begin
            locked <= 1'b1;
            if (load_edge) begin
              ol_first <= 1'b1;
              if (!fifo_empty) begin
                ol_data <= head_lo;
                hold    <= head_hi;
              end else if (uf_cnt_q != UF_CNT_MAX) begin
                uf_cnt_q <= uf_cnt_q + 1'b1;
              end
            end else begin
              ol_data <= hold;
            end
          end
        end

        default: begin
          state    <= ST_UNLOCKED;
          lock_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ologic_tx_gearbox.sv
// tb_ologic_tx_gearbox
//   Self-checking bench for ologic_tx_gearbox. A queue-based model predicts
//   every output each cycle; directed sequences add literal expectations for
//   lock, ordering, underflow/saturation, backpressure, alignment loss and
//   reset in the middle of a word.
module tb_ologic_tx_gearbox;

  localparam int DW       = 4;
  localparam int LANES    = 8;
  localparam int DEPTH    = 4;
  localparam int LOCK_CNT = 4;

  logic        gsclk_ol  = 1'b0;
  logic        rst       = 1'b1;
  logic        align_ol  = 1'b0;
  logic        in_valid  = 1'b0;
  logic [63:0] in_data   = '0;
  logic        in_ready;
  logic [31:0] ol_data;
  logic        ol_first;
  logic        locked;
  logic        align_err;
  logic [15:0] underflow_cnt;

  int checks   = 0;
  int failures = 0;
  bit cur_a    = 1'b0;

  always #5 gsclk_ol = ~gsclk_ol;

  ologic_tx_gearbox #(
    .DW         (DW),
    .LANES      (LANES),
    .FIFO_DEPTH (DEPTH),
    .LOCK_CNT   (LOCK_CNT),
    .IDLE_PAT   (4'h0)
  ) dut (
    .gsclk_ol      (gsclk_ol),
    .rst           (rst),
    .align_ol      (align_ol),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .ol_data       (ol_data),
    .ol_first      (ol_first),
    .locked        (locked),
    .align_err     (align_err),
    .underflow_cnt (underflow_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lo_half(input logic [63:0] w);
    logic [31:0] r = '0;
    for (int l = 0; l < LANES; l++) r[l*4 +: 4] = w[l*8 +: 4];
    return r;
  endfunction

  function automatic logic [31:0] hi_half(input logic [63:0] w);
    logic [31:0] r = '0;
    for (int l = 0; l < LANES; l++) r[l*4 +: 4] = w[l*8 + 4 +: 4];
    return r;
  endfunction

  // ---------------- behavioural model ----------------
  bit          m_on = 1'b0;
  bit          m_run;
  int          m_streak;
  bit          m_prev;
  logic [63:0] m_q[$];
  logic [31:0] m_pend;
  int          m_uf;
  logic [31:0] e_data;
  bit          e_first, e_locked, e_err;
  bit          m_tog, m_acc;
  logic [63:0] m_w;

  always @(posedge gsclk_ol) begin
    if (rst) begin
      m_on = 1'b1; m_run = 1'b0; m_streak = 0; m_prev = 1'b0;
      m_q.delete(); m_pend = '0; m_uf = 0;
      e_data = '0; e_first = 1'b0; e_locked = 1'b0; e_err = 1'b0;
    end else if (m_on) begin
      m_tog  = (align_ol != m_prev);
      m_prev = align_ol;
      m_acc  = in_valid && e_locked && (m_q.size() < DEPTH);
      e_err = 1'b0; e_data = '0; e_first = 1'b0;
      if (!m_run) begin
        m_streak = m_tog ? m_streak + 1 : 0;
        if (m_streak >= LOCK_CNT) begin
          m_run = 1'b1;
          m_streak = 0;
        end
        m_pend = '0;
      end else if (!m_tog) begin
        m_run = 1'b0; m_streak = 0; e_err = 1'b1;
        m_q.delete(); m_acc = 1'b0; m_pend = '0;
      end else if (align_ol) begin
        e_first = 1'b1;
        if (m_q.size() > 0) begin
          m_w    = m_q.pop_front();
          e_data = lo_half(m_w);
          m_pend = hi_half(m_w);
        end else begin
          m_pend = '0;
          if (m_uf < 65535) m_uf++;
        end
      end else begin
        e_data = m_pend;
        m_pend = '0;
      end
      if (m_acc) m_q.push_back(in_data);
      e_locked = m_run;
    end
    #1;
    if (m_on) begin
      check("cyc_ol_data",   64'(ol_data),       64'(e_data));
      check("cyc_ol_first",  64'(ol_first),      64'(e_first));
      check("cyc_locked",    64'(locked),        64'(e_locked));
      check("cyc_align_err", 64'(align_err),     64'(e_err));
      check("cyc_underflow", 64'(underflow_cnt), 64'(m_uf));
      check("cyc_in_ready",  64'(in_ready),      64'(e_locked && (m_q.size() < DEPTH)));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input bit a, input bit v, input logic [63:0] d);
    align_ol = a; in_valid = v; in_data = d; cur_a = a;
    @(negedge gsclk_ol);
  endtask

  task automatic tog(input bit v, input logic [63:0] d);
    step(!cur_a, v, d);
  endtask

  localparam logic [63:0] W1 = {8{8'hA5}};
  localparam logic [63:0] W2 = 64'h0123_4567_89AB_CDEF;

  initial begin
    bit found;
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    // Reset for three edges.
    repeat (3) @(negedge gsclk_ol);
    check("rst_locked",   64'(locked),        64'd0);
    check("rst_ol_data",  64'(ol_data),       64'd0);
    check("rst_ol_first", 64'(ol_first),      64'd0);
    check("rst_uf",       64'(underflow_cnt), 64'd0);
    check("rst_in_ready", 64'(in_ready),      64'd0);
    rst = 1'b0;

    // Lock acquisition: locked only after the 4th consecutive toggle.
    repeat (3) tog(1'b0, '0);
    check("lock_3_locked",   64'(locked),   64'd0);
    check("lock_3_in_ready", 64'(in_ready), 64'd0);
    tog(1'b0, '0);
    check("lock_4_locked",   64'(locked),   64'd1);
    check("lock_4_in_ready", 64'(in_ready), 64'd1);
    check("lock_4_ol_data",  64'(ol_data),  64'd0);

    // Underflow: three empty load slots.
    repeat (3) begin
      tog(1'b0, '0);
      check("uf_first_hi", 64'(ol_first), 64'd1);
      check("uf_data_lo",  64'(ol_data),  64'd0);
      tog(1'b0, '0);
      check("uf_first_lo", 64'(ol_first), 64'd0);
    end
    check("uf_cnt_3", 64'(underflow_cnt), 64'd3);

    // Data ordering: W1 pushed on a load edge with the FIFO empty, W2 next.
    tog(1'b1, W1);
    tog(1'b1, W2);
    tog(1'b0, '0);
    check("ord_w1_lo", 64'(ol_data), 64'h5555_5555);
    check("ord_w1_first", 64'(ol_first), 64'd1);
    tog(1'b0, '0);
    check("ord_w1_hi", 64'(ol_data), 64'hAAAA_AAAA);
    tog(1'b0, '0);
    check("ord_w2_lo", 64'(ol_data), 64'h1357_9BDF);
    check("ord_w2_first", 64'(ol_first), 64'd1);
    tog(1'b0, '0);
    check("ord_w2_hi", 64'(ol_data), 64'h0246_8ACE);
    check("ord_uf_cnt", 64'(underflow_cnt), 64'd4);

    // Saturation of the underflow counter.
    force dut.uf_cnt_q = 16'hFFFE;
    m_uf = 16'hFFFE;
    #1;
    release dut.uf_cnt_q;
    repeat (3) begin
      tog(1'b0, '0);
      tog(1'b0, '0);
    end
    check("uf_saturate", 64'(underflow_cnt), 64'hFFFF);

    // Backpressure: one push per cycle, one pop per two cycles.
    for (int k = 0; k < 8; k++) begin
      tog(1'b1, {8{4'(k + 1), 4'(k + 9)}});
      if (k == 5) check("bp_full_6", 64'(in_ready), 64'd0);
      if (k == 6) check("bp_room_7", 64'(in_ready), 64'd1);
      if (k == 7) check("bp_full_8", 64'(in_ready), 64'd0);
    end

    // Alignment loss with words still queued.
    step(cur_a, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    check("loss_err",      64'(align_err), 64'd1);
    check("loss_locked",   64'(locked),    64'd0);
    check("loss_in_ready", 64'(in_ready),  64'd0);
    check("loss_ol_data",  64'(ol_data),   64'd0);
    step(cur_a, 1'b0, '0);
    check("loss_err_once", 64'(align_err), 64'd0);
    check("loss_idle",     64'(ol_data),   64'd0);
    repeat (10) tog(1'b0, '0);
    check("relock", 64'(locked), 64'd1);

    // Reset in the middle of a word.
    tog(1'b1, W2);
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      tog(1'b0, '0);
      if (ol_first && ol_data != '0) found = 1'b1;
    end
    check("mid_reach_first", 64'(found), 64'd1);
    check("mid_lo", 64'(ol_data), 64'h1357_9BDF);
    rst = 1'b1;
    step(1'b0, 1'b0, '0);
    check("mid_rst_data",   64'(ol_data),       64'd0);
    check("mid_rst_first",  64'(ol_first),      64'd0);
    check("mid_rst_locked", 64'(locked),        64'd0);
    check("mid_rst_uf",     64'(underflow_cnt), 64'd0);
    rst = 1'b0;
    repeat (3) step(1'b0, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
